i2c_reg_slave: RTL and testbench

I2C_REG_SLAVE -- requirements
Module: i2c_reg_slave

---
 rtl/i2c_reg_slave.sv | 326 ++++++++++++++++++++++++++++++++
 tb/tb_i2c_reg_slave.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_slave.sv
// i2c_reg_slave -- I2C target exposing a small bank of 8-bit registers.
//
// Protocol handled:
//   write: [S][addr+W][ptr][data]...[P]   data bytes land in regs[ptr]
//   read : [S][addr+R][data]...[NACK][P]  data comes from regs[ptr]
//   A repeated START may follow the pointer byte to turn the access into a read.
//   A read without a preceding pointer byte uses whatever pointer is current.
//
// Build option:
//   I2C_REG_SLAVE_AUTOINC_EN  when defined, the pointer advances after every
//                             written or transmitted byte, wrapping
//                             NUM_REGS-1 -> 0. When undefined, the pointer
//                             stays fixed for the whole transaction.
//
// Ports:
//   clk        system clock (100 MHz)
//   rst        asynchronous, active-high reset
//   scl        I2C clock from the master
//   sda        I2C data, open drain: only ever driven low, otherwise Z
//   regs       register file contents, reg k at bits [8k+7:8k]
//   wr_strobe  one-clk pulse when a register is written
//   wr_idx     index of the written register, valid with wr_strobe
//   busy       high whenever the protocol FSM is not idle
module i2c_reg_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h55,
  parameter int         NUM_REGS   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        scl,
  inout  wire                         sda,
  output logic [NUM_REGS*8-1:0]       regs,
  output logic                        wr_strobe,
  output logic [$clog2(NUM_REGS)-1:0] wr_idx,
  output logic                        busy
);

  localparam int             PW         = $clog2(NUM_REGS);
  localparam logic [PW-1:0]  PTR_MAX    = PW'(NUM_REGS - 1);
  localparam logic [7:0]     NUM_REGS_B = 8'(NUM_REGS);

`ifdef I2C_REG_SLAVE_AUTOINC_EN
  localparam logic AUTOINC = 1'b1;
`else
  localparam logic AUTOINC = 1'b0;
`endif

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    RX_DEV    = 4'd1,
    DEV_ACK   = 4'd2,
    RX_PTR    = 4'd3,
    PTR_ACK   = 4'd4,
    RX_DATA   = 4'd5,
    DATA_ACK  = 4'd6,
    TX_DATA   = 4'd7,
    TX_ACK    = 4'd8,
    WAIT_STOP = 4'd9
  } state_t;

  // Pointer advance with wrap at the last implemented register.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    if (p == PTR_MAX) begin
      ptr_next = {PW{1'b0}};
    end else begin
      ptr_next = p + PW'(1);
    end
  endfunction

  // Bus synchronisers: bit [2] is the oldest sample, bit [1] the newest one
  // used for decisions, so edges are seen as [2] != [1].
  logic [2:0] scl_sync_q;
  logic [2:0] sda_sync_q;

  logic scl_rise_s, scl_fall_s, start_s, stop_s, sda_s, scl_hi_s;

  state_t         state_q, state_d;
  logic [3:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic [7:0]     tx_q, tx_d;
  logic [PW-1:0]  ptr_q, ptr_d;
  logic           rw_q, rw_d;
  logic           mack_q, mack_d;
  logic           sda_oe_q, sda_oe_d;
  logic [7:0]     regs_q [NUM_REGS];
  logic [7:0]     regs_d [NUM_REGS];
  logic           wr_strobe_q, wr_strobe_d;
  logic [PW-1:0]  wr_idx_q, wr_idx_d;

  logic           rx_state_s;
  logic           byte_done_s;

  // Three-flop synchronisers for the asynchronous bus lines.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync_q <= 3'b111;
      sda_sync_q <= 3'b111;
    end else begin
      scl_sync_q <= {scl_sync_q[1:0], scl};
      sda_sync_q <= {sda_sync_q[1:0], sda};
    end
  end

  // Bus event decode from the synchronised samples.
  always_comb begin
    sda_s      = sda_sync_q[1];
    scl_hi_s   = scl_sync_q[1] & scl_sync_q[2];
    scl_rise_s = scl_sync_q[1] & ~scl_sync_q[2];
    scl_fall_s = ~scl_sync_q[1] & scl_sync_q[2];
    start_s    = scl_hi_s & sda_sync_q[2] & ~sda_sync_q[1];
    stop_s     = scl_hi_s & ~sda_sync_q[2] & sda_sync_q[1];
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 4'd0;
      shift_q     <= 8'h00;
      tx_q        <= 8'h00;
      ptr_q       <= {PW{1'b0}};
      rw_q        <= 1'b0;
      mack_q      <= 1'b0;
      sda_oe_q    <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_idx_q    <= {PW{1'b0}};
      for (int k = 0; k < NUM_REGS; k++) begin
        regs_q[k] <= 8'h00;
      end
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      ptr_q       <= ptr_d;
      rw_q        <= rw_d;
      mack_q      <= mack_d;
      sda_oe_q    <= sda_oe_d;
      wr_strobe_q <= wr_strobe_d;
      wr_idx_q    <= wr_idx_d;
      for (int k = 0; k < NUM_REGS; k++) begin
        regs_q[k] <= regs_d[k];
      end
    end
  end

  // Next-state and datapath logic.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    tx_d        = tx_q;
    ptr_d       = ptr_q;
    rw_d        = rw_q;
    mack_d      = mack_q;
    sda_oe_d    = sda_oe_q;
    wr_strobe_d = 1'b0;
    wr_idx_d    = wr_idx_q;
    regs_d      = regs_q;

    rx_state_s  = (state_q == RX_DEV) || (state_q == RX_PTR) || (state_q == RX_DATA);
    // bit_cnt reaches 8 on the 8th rise; the following fall closes the byte.
    byte_done_s = (bit_cnt_q == 4'd8) && scl_fall_s;

    if ((state_q != IDLE) && stop_s) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
    end else if (start_s) begin
      // Plain START from IDLE and repeated START elsewhere behave the same.
      state_d   = RX_DEV;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
    end else if (rx_state_s && scl_rise_s && (bit_cnt_q != 4'd8)) begin
      shift_d   = {shift_q[6:0], sda_s};
      bit_cnt_d = bit_cnt_q + 4'd1;
    end else begin
      case (state_q)
        RX_DEV: begin
          if (byte_done_s) begin
            if (shift_q[7:1] == SLAVE_ADDR) begin
              state_d  = DEV_ACK;
              rw_d     = shift_q[0];
              sda_oe_d = 1'b1;
            end else begin
              state_d  = WAIT_STOP;
              sda_oe_d = 1'b0;
            end
          end else begin
            state_d = RX_DEV;
          end
        end

        DEV_ACK: begin
          if (scl_fall_s) begin
            bit_cnt_d = 4'd0;
            if (rw_q) begin
              // The fall ending the ACK also puts out bit 7 of the read data.
              state_d  = TX_DATA;
              tx_d     = regs_q[ptr_q];
              sda_oe_d = ~regs_q[ptr_q][7];
            end else begin
              state_d  = RX_PTR;
              sda_oe_d = 1'b0;
            end
          end else begin
            state_d = DEV_ACK;
          end
        end

        RX_PTR: begin
          if (byte_done_s) begin
            if (shift_q < NUM_REGS_B) begin
              state_d  = PTR_ACK;
              ptr_d    = shift_q[PW-1:0];
              sda_oe_d = 1'b1;
            end else begin
              state_d  = WAIT_STOP;
              sda_oe_d = 1'b0;
            end
          end else begin
            state_d = RX_PTR;
          end
        end

        PTR_ACK: begin
          if (scl_fall_s) begin
            state_d   = RX_DATA;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
          end else begin
            state_d = PTR_ACK;
          end
        end

        RX_DATA: begin
          if (byte_done_s) begin
            state_d  = DATA_ACK;
            sda_oe_d = 1'b1;
          end else begin
            state_d = RX_DATA;
          end
        end

        DATA_ACK: begin
          // Commit only once the ACK bit is over, so an interrupted ACK
          // never leaves a half-acknowledged write behind.
          if (scl_fall_s) begin
            regs_d[ptr_q] = shift_q;
            wr_strobe_d   = 1'b1;
            wr_idx_d      = ptr_q;
            ptr_d         = AUTOINC ? ptr_next(ptr_q) : ptr_q;
            state_d       = RX_DATA;
            bit_cnt_d     = 4'd0;
            sda_oe_d      = 1'b0;
          end else begin
            state_d = DATA_ACK;
          end
        end

        TX_DATA: begin
          // bit_cnt counts bits already on the bus beyond bit 7.
          if (scl_fall_s) begin
            if (bit_cnt_q == 4'd7) begin
              state_d  = TX_ACK;
              sda_oe_d = 1'b0;
              mack_d   = 1'b0;
              ptr_d    = AUTOINC ? ptr_next(ptr_q) : ptr_q;
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
              tx_d      = {tx_q[6:0], 1'b0};
              sda_oe_d  = ~tx_q[6];
            end
          end else begin
            state_d = TX_DATA;
          end
        end

        TX_ACK: begin
          if (scl_rise_s) begin
            if (sda_s) begin
              state_d = WAIT_STOP;
            end else begin
              mack_d = 1'b1;
            end
          end else if (scl_fall_s && mack_q) begin
            state_d   = TX_DATA;
            bit_cnt_d = 4'd0;
            tx_d      = regs_q[ptr_q];
            sda_oe_d  = ~regs_q[ptr_q][7];
          end else begin
            state_d = TX_ACK;
          end
        end

        WAIT_STOP: begin
          sda_oe_d = 1'b0;
        end

        IDLE: begin
          sda_oe_d = 1'b0;
        end

        default: begin
          state_d  = IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  // Output decode; busy follows the state directly.
  always_comb begin
    busy      = (state_q != IDLE);
    wr_strobe = wr_strobe_q;
    wr_idx    = wr_idx_q;
  end

  // Open-drain pad: low or released, never driven high.
  assign sda = sda_oe_q ? 1'b0 : 1'bz;

  // Flatten the register array onto the output bus.
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
    assign regs[8*g +: 8] = regs_q[g];
  end

endmodule

// File: tb/tb_i2c_reg_slave.sv
module tb_i2c_reg_slave;

  localparam int Q = 8;  // clk cycles per quarter of an I2C bit

`ifdef I2C_REG_SLAVE_AUTOINC_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scl = 1'b1;
  logic        m_low = 1'b0;
  wire         sda_w;
  logic [31:0] regs;
  logic        wr_strobe;
  logic [1:0]  wr_idx;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  int strobe_cnt = 0;
  int last_idx   = 0;
  int drive_cnt  = 0;
  bit strobe_long = 1'b0;
  bit strobe_prev = 1'b0;

  pullup (sda_w);
  assign sda_w = m_low ? 1'b0 : 1'bz;

  i2c_reg_slave #(.SLAVE_ADDR(7'h55), .NUM_REGS(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .scl      (scl),
    .sda      (sda_w),
    .regs     (regs),
    .wr_strobe(wr_strobe),
    .wr_idx   (wr_idx),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Bus and strobe monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (wr_strobe) begin
      strobe_cnt++;
      last_idx = int'(wr_idx);
      if (strobe_prev) strobe_long = 1'b1;
    end
    strobe_prev = wr_strobe;
    if (!m_low && sda_w == 1'b0) drive_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
  endtask

  // START, also usable as a repeated START from scl low.
  task automatic i2c_start;
    m_low = 1'b0; tick(Q);
    scl   = 1'b1; tick(Q);
    m_low = 1'b1; tick(Q);
    scl   = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop;
    m_low = 1'b1; tick(Q);
    scl   = 1'b1; tick(Q);
    m_low = 1'b0; tick(Q);
  endtask

  task automatic send_bit(input bit b, output bit rb);
    m_low = ~b; tick(Q);
    scl   = 1'b1; tick(Q);
    @(negedge clk) rb = sda_w;
    tick(Q);
    scl = 1'b0; tick(Q);
  endtask

  // ack returns the bus level in the ACK slot (0 = acknowledged).
  task automatic write_byte(input logic [7:0] d, output bit ack);
    bit dummy;
    for (int i = 7; i >= 0; i--) send_bit(d[i], dummy);
    send_bit(1'b1, ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input bit nack);
    bit rb;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, rb);
      d[i] = rb;
    end
    send_bit(nack, rb);
  endtask

  initial begin
    bit         ack;
    bit         dummy;
    logic [7:0] d0, d1;
    int         snap;

    // Reset state
    tick(5);
    @(negedge clk);
    check_eq("rst_regs", regs, 32'h0000_0000);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_strobe", {31'd0, wr_strobe}, 32'd0);
    check_eq("rst_idx", {30'd0, wr_idx}, 32'd0);
    check_eq("rst_sda", {31'd0, sda_w}, 32'd1);
    rst = 1'b0;
    tick(5);

    // Write 0x3C to reg 1
    i2c_start;
    check_eq("busy_after_start", {31'd0, busy}, 32'd1);
    write_byte(8'hAA, ack); check_eq("w1_dev_ack", {31'd0, ack}, 32'd0);
    write_byte(8'h01, ack); check_eq("w1_ptr_ack", {31'd0, ack}, 32'd0);
    write_byte(8'h3C, ack); check_eq("w1_dat_ack", {31'd0, ack}, 32'd0);
    i2c_stop; tick(Q);
    check_eq("w1_regs", regs, 32'h0000_3C00);
    check_eq("w1_strobes", strobe_cnt, 32'd1);
    check_eq("w1_idx", last_idx, 32'd1);
    check_eq("w1_busy", {31'd0, busy}, 32'd0);

    // Load reg 2 = 0x96, then read it back through a repeated START
    i2c_start;
    write_byte(8'hAA, ack);
    write_byte(8'h02, ack);
    write_byte(8'h96, ack); check_eq("w2_dat_ack", {31'd0, ack}, 32'd0);
    i2c_stop; tick(Q);
    check_eq("w2_regs", regs, 32'h0096_3C00);
    i2c_start;
    write_byte(8'hAA, ack);
    write_byte(8'h02, ack); check_eq("r1_ptr_ack", {31'd0, ack}, 32'd0);
    i2c_start;
    write_byte(8'hAB, ack); check_eq("r1_dev_ack", {31'd0, ack}, 32'd0);
    read_byte(d0, 1'b1);
    i2c_stop; tick(Q);
    check_eq("r1_data", {24'd0, d0}, 32'h96);
    check_eq("r1_busy", {31'd0, busy}, 32'd0);

    // Read with no pointer byte: reuse the current pointer
    i2c_start;
    write_byte(8'hAB, ack);
    read_byte(d0, 1'b1);
    i2c_stop; tick(Q);
    check_eq("r2_noptr", {24'd0, d0}, AUTO ? 32'h00 : 32'h96);

    // Two-byte read from reg 1
    i2c_start;
    write_byte(8'hAA, ack);
    write_byte(8'h01, ack);
    i2c_start;
    write_byte(8'hAB, ack);
    read_byte(d0, 1'b0);
    read_byte(d1, 1'b1);
    i2c_stop; tick(Q);
    check_eq("r3_byte0", {24'd0, d0}, 32'h3C);
    check_eq("r3_byte1", {24'd0, d1}, AUTO ? 32'h96 : 32'h3C);

    // Two data bytes from pointer 3: wrap or overwrite
    i2c_start;
    write_byte(8'hAA, ack);
    write_byte(8'h03, ack);
    write_byte(8'h11, ack);
    write_byte(8'h22, ack); check_eq("w3_dat2_ack", {31'd0, ack}, 32'd0);
    i2c_stop; tick(Q);
    check_eq("w3_regs", regs, AUTO ? 32'h1196_3C22 : 32'h2296_3C00);
    check_eq("w3_strobes", strobe_cnt, 32'd4);
    check_eq("w3_idx", last_idx, AUTO ? 32'd0 : 32'd3);

    // Foreign address, then out-of-range pointer
    snap = drive_cnt;
    i2c_start;
    write_byte(8'hA0, ack); check_eq("foreign_nack", {31'd0, ack}, 32'd1);
    send_bit(1'b1, dummy);
    check_eq("foreign_nodrive", drive_cnt - snap, 32'd0);
    i2c_stop; tick(Q);
    check_eq("foreign_busy", {31'd0, busy}, 32'd0);
    i2c_start;
    write_byte(8'hAA, ack); check_eq("badptr_dev_ack", {31'd0, ack}, 32'd0);
    write_byte(8'h07, ack); check_eq("badptr_nack", {31'd0, ack}, 32'd1);
    i2c_stop; tick(Q);
    check_eq("badptr_strobes", strobe_cnt, 32'd4);
    i2c_start;
    write_byte(8'hAB, ack);
    read_byte(d0, 1'b1);
    i2c_stop; tick(Q);
    check_eq("badptr_keep", {24'd0, d0}, AUTO ? 32'h3C : 32'h22);

    // Reset during bit 5 of a data byte (0x5A = 0101_1010)
    i2c_start;
    write_byte(8'hAA, ack);
    write_byte(8'h00, ack);
    send_bit(1'b0, dummy);
    send_bit(1'b1, dummy);
    m_low = 1'b1; tick(Q / 2);
    rst = 1'b1; tick(2);
    @(negedge clk);
    check_eq("midrst_busy", {31'd0, busy}, 32'd0);
    check_eq("midrst_regs", regs, 32'h0000_0000);
    rst = 1'b0; tick(Q / 2);
    scl = 1'b1; tick(2 * Q);
    scl = 1'b0; tick(Q);
    send_bit(1'b1, dummy);
    send_bit(1'b1, dummy);
    send_bit(1'b0, dummy);
    send_bit(1'b1, dummy);
    send_bit(1'b0, dummy);
    send_bit(1'b1, ack); check_eq("midrst_ignored", {31'd0, ack}, 32'd1);
    i2c_stop; tick(Q);
    check_eq("midrst_strobes", strobe_cnt, 32'd4);
    i2c_start;
    write_byte(8'hAA, ack);
    write_byte(8'h00, ack);
    write_byte(8'h5A, ack); check_eq("post_rst_ack", {31'd0, ack}, 32'd0);
    i2c_stop; tick(Q);
    check_eq("post_rst_regs", regs, 32'h0000_005A);
    check_eq("post_rst_strobes", strobe_cnt, 32'd5);
    check_eq("post_rst_idx", last_idx, 32'd0);
    check_eq("strobe_width", {31'd0, strobe_long}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
